// File: rtl/fpu_mul_param.sv
// fpu_mul_param
//   Parametrised IEEE-754 binary floating-point multiplier. It works through a
//   multi-cycle FSM: IDLE -> UNPACK -> MULT -> NORM -> ROUND -> PACK -> OUT.
//   UNPACK resolves special operands and jumps straight to OUT.
//
// Parameters
//   EXP_W      exponent field width (>= 3)
//   MAN_W      stored fraction width (>= 2); word width W = 1+EXP_W+MAN_W
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   operand pair valid
//   in_ready   block can accept operands (high only in IDLE)
//   din1/din2  IEEE operands
//   rm         rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM, 5..7 as RNE
//   out_valid  result valid; result and flags are held until accepted
//   out_ready  consumer accepts result
//   result     product
//   flags      {NV, DZ, OF, UF, NX}; DZ is always 0
module fpu_mul_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   din1,
  input  logic [EXP_W+MAN_W:0]   din2,
  input  logic [2:0]             rm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [4:0]             flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int M    = MAN_W + 1;          // mantissa including hidden bit
  localparam int PW   = 2 * M;              // raw product width
  localparam int EW   = EXP_W + 2;          // signed internal exponent width
  localparam int GW   = M + 2;              // mantissa + guard + round
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;

  localparam logic signed [EW-1:0] EBIAS = EW'(BIAS);
  localparam logic signed [EW-1:0] EMIN  = EW'(1 - BIAS);
  localparam logic signed [EW-1:0] EONE  = EW'(1);
  localparam logic signed [EW-1:0] SHMAX = EW'(GW);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_MULT, S_NORM, S_ROUND, S_PACK, S_OUT
  } state_e;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0, RM_RTZ = 3'd1, RM_RDN = 3'd2, RM_RUP = 3'd3, RM_RMM = 3'd4
  } rm_e;

  state_e                r_state;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [W-1:0]          r_result;
  logic [4:0]            r_flags;
  logic [W-1:0]          r_a;
  logic [W-1:0]          r_b;
  logic [2:0]            r_rm;
  logic                  r_s;
  logic [M-1:0]          r_m1;
  logic [M-1:0]          r_m2;
  logic signed [EW-1:0]  r_e1;
  logic signed [EW-1:0]  r_e2;
  logic [PW-1:0]         r_prod;
  logic signed [EW-1:0]  r_e;
  logic [M-1:0]          r_mant;
  logic                  r_g;
  logic                  r_r;
  logic                  r_st;
  logic                  r_den;
  logic                  r_nx;
  logic                  r_uf;

  // Leading zeros of a mantissa word (hidden-bit position included).
  function automatic logic [EW-1:0] f_lzc(input logic [M-1:0] v);
    logic [EW-1:0] n;
    logic          found;
    n     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < M; i++) begin
      if (!found && v[M-1-i]) found = 1'b1;
      else if (!found)        n = n + EW'(1);
    end
    return n;
  endfunction

  // ---------------- UNPACK: field split, classification, specials
  logic                 w_s1, w_s2, w_s;
  logic [EXP_W-1:0]     w_ex1, w_ex2;
  logic [MAN_W-1:0]     w_fr1, w_fr2;
  logic                 w_nan1, w_nan2, w_inf1, w_inf2, w_zero1, w_zero2;
  logic                 w_sub1, w_sub2;
  logic [EW-1:0]        w_lz1, w_lz2;
  logic [M-1:0]         w_m1, w_m2;
  logic signed [EW-1:0] w_e1, w_e2;
  logic                 w_special;
  logic [W-1:0]         w_sp_result;
  logic [4:0]           w_sp_flags;
  logic [W-1:0]         w_qnan;

  assign w_s1  = r_a[W-1];
  assign w_s2  = r_b[W-1];
  assign w_s   = w_s1 ^ w_s2;
  assign w_ex1 = r_a[W-2 -: EXP_W];
  assign w_ex2 = r_b[W-2 -: EXP_W];
  assign w_fr1 = r_a[MAN_W-1:0];
  assign w_fr2 = r_b[MAN_W-1:0];

  assign w_nan1  = (&w_ex1) & (|w_fr1);
  assign w_nan2  = (&w_ex2) & (|w_fr2);
  assign w_inf1  = (&w_ex1) & ~(|w_fr1);
  assign w_inf2  = (&w_ex2) & ~(|w_fr2);
  assign w_zero1 = ~(|w_ex1) & ~(|w_fr1);
  assign w_zero2 = ~(|w_ex2) & ~(|w_fr2);
  assign w_sub1  = ~(|w_ex1) & (|w_fr1);
  assign w_sub2  = ~(|w_ex2) & (|w_fr2);

  // Subnormals are normalised here: shift until the hidden bit is set and
  // lower the exponent by the same amount.
  assign w_lz1 = f_lzc({1'b0, w_fr1});
  assign w_lz2 = f_lzc({1'b0, w_fr2});
  assign w_m1  = w_sub1 ? ({1'b0, w_fr1} << w_lz1) : {1'b1, w_fr1};
  assign w_m2  = w_sub2 ? ({1'b0, w_fr2} << w_lz2) : {1'b1, w_fr2};
  assign w_e1  = w_sub1 ? (EMIN - $signed(w_lz1)) : ($signed({2'b00, w_ex1}) - EBIAS);
  assign w_e2  = w_sub2 ? (EMIN - $signed(w_lz2)) : ($signed({2'b00, w_ex2}) - EBIAS);

  assign w_qnan = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  always_comb begin
    w_special   = 1'b1;
    w_sp_result = '0;
    w_sp_flags  = '0;
    if (w_nan1 || w_nan2) begin
      // Only a signalling NaN (fraction MSB clear) raises NV.
      w_sp_result = w_qnan;
      w_sp_flags  = {(w_nan1 & ~w_fr1[MAN_W-1]) | (w_nan2 & ~w_fr2[MAN_W-1]), 4'b0000};
    end else if ((w_inf1 && w_zero2) || (w_zero1 && w_inf2)) begin
      w_sp_result = w_qnan;
      w_sp_flags  = 5'b10000;
    end else if (w_inf1 || w_inf2) begin
      w_sp_result = {w_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_zero1 || w_zero2) begin
      w_sp_result = {w_s, {(EXP_W+MAN_W){1'b0}}};
    end else begin
      w_special = 1'b0;
    end
  end

  // ---------------- NORM: one-bit normalise, then denormalise if tiny
  logic [PW-1:0]         w_pn;
  logic signed [EW-1:0]  w_en;
  logic [M-1:0]          w_mn;
  logic                  w_gn, w_rn, w_sn;
  logic                  w_tiny;
  logic signed [EW-1:0]  w_shf;
  logic signed [EW-1:0]  w_sh;
  logic [2*GW-1:0]       w_dx;

  assign w_pn   = r_prod[PW-1] ? r_prod : {r_prod[PW-2:0], 1'b0};
  assign w_en   = r_prod[PW-1] ? (r_e + EONE) : r_e;
  assign w_mn   = w_pn[PW-1 -: M];
  assign w_gn   = w_pn[M-1];
  assign w_rn   = w_pn[M-2];
  assign w_sn   = |w_pn[M-3:0];
  assign w_tiny = (w_en < EMIN);
  assign w_shf  = EMIN - w_en;
  assign w_sh   = (w_shf > SHMAX) ? SHMAX : w_shf;
  // Lower half collects the bits pushed out of the guard/round window.
  assign w_dx   = {w_mn, w_gn, w_rn, {GW{1'b0}}} >> w_sh;

  // ---------------- ROUND
  logic         w_grs;
  logic         w_inc;
  logic [M:0]   w_sum;

  assign w_grs = r_g | r_r | r_st;

  always_comb begin
    w_inc = 1'b0;
    case (r_rm)
      RM_RTZ:  w_inc = 1'b0;
      RM_RDN:  w_inc = w_grs & r_s;
      RM_RUP:  w_inc = w_grs & ~r_s;
      RM_RMM:  w_inc = r_g;
      default: w_inc = r_g & (r_r | r_st | r_mant[0]);
    endcase
  end

  assign w_sum = {1'b0, r_mant} + {{M{1'b0}}, w_inc};

  // ---------------- PACK
  logic               w_ovf;
  logic               w_ovf_inf;
  logic [EXP_W-1:0]   w_efield;
  logic [W-1:0]       w_pk_result;
  logic [4:0]         w_pk_flags;

  assign w_ovf    = (r_e > EBIAS);
  assign w_efield = r_e[EXP_W-1:0] + EBIAS[EXP_W-1:0];

  always_comb begin
    w_ovf_inf = 1'b1;
    case (r_rm)
      RM_RTZ:  w_ovf_inf = 1'b0;
      RM_RDN:  w_ovf_inf = r_s;
      RM_RUP:  w_ovf_inf = ~r_s;
      default: w_ovf_inf = 1'b1;
    endcase
  end

  always_comb begin
    w_pk_result = '0;
    w_pk_flags  = '0;
    if (w_ovf) begin
      w_pk_flags  = 5'b00101;
      w_pk_result = w_ovf_inf ? {r_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                              : {r_s, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    end else begin
      w_pk_flags  = {3'b000, r_uf, r_nx};
      w_pk_result = {r_s, (r_mant[M-1] ? w_efield : {EXP_W{1'b0}}), r_mant[MAN_W-1:0]};
    end
  end

  // ---------------- control and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rm        <= '0;
      r_s         <= 1'b0;
      r_m1        <= '0;
      r_m2        <= '0;
      r_e1        <= '0;
      r_e2        <= '0;
      r_prod      <= '0;
      r_e         <= '0;
      r_mant      <= '0;
      r_g         <= 1'b0;
      r_r         <= 1'b0;
      r_st        <= 1'b0;
      r_den       <= 1'b0;
      r_nx        <= 1'b0;
      r_uf        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= din1;
            r_b        <= din2;
            r_rm       <= rm;
            r_in_ready <= 1'b0;
            r_state    <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          r_s <= w_s;
          if (w_special) begin
            r_result <= w_sp_result;
            r_flags  <= w_sp_flags;
            r_state  <= S_OUT;
          end else begin
            r_m1    <= w_m1;
            r_m2    <= w_m2;
            r_e1    <= w_e1;
            r_e2    <= w_e2;
            r_state <= S_MULT;
          end
        end
        S_MULT: begin
          r_prod  <= {{M{1'b0}}, r_m1} * {{M{1'b0}}, r_m2};
          r_e     <= r_e1 + r_e2;
          r_state <= S_NORM;
        end
        S_NORM: begin
          if (w_tiny) begin
            r_mant <= w_dx[2*GW-1 -: M];
            r_g    <= w_dx[GW+1];
            r_r    <= w_dx[GW];
            r_st   <= w_sn | (|w_dx[GW-1:0]);
            r_e    <= EMIN;
            r_den  <= 1'b1;
          end else begin
            r_mant <= w_mn;
            r_g    <= w_gn;
            r_r    <= w_rn;
            r_st   <= w_sn;
            r_e    <= w_en;
            r_den  <= 1'b0;
          end
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          // A denormal rounding into the hidden bit needs no exponent change:
          // hidden=1 at EMIN is already the minimum normal.
          if (w_sum[M]) begin
            r_mant <= w_sum[M:1];
            r_e    <= r_e + EONE;
          end else begin
            r_mant <= w_sum[M-1:0];
          end
          r_nx    <= w_grs;
          r_uf    <= r_den & w_grs;
          r_state <= S_PACK;
        end
        S_PACK: begin
          r_result <= w_pk_result;
          r_flags  <= w_pk_flags;
          r_state  <= S_OUT;
        end
        S_OUT: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;

endmodule

// File: tb/tb_fpu_mul_param.sv
// tb_fpu_mul_param
//   Directed self-checking bench for fpu_mul_param: a single-precision
//   instance (EXP_W=8, MAN_W=23) and a half-precision instance (EXP_W=5,
//   MAN_W=10) sharing clock and reset. Expected values are hand-computed.
module tb_fpu_mul_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] din1, din2, result;
  logic [2:0]  rm;
  logic [4:0]  flags;

  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_din1, h_din2, h_result;
  logic [2:0]  h_rm;
  logic [4:0]  h_flags;

  int total = 0;
  int bad   = 0;

  fpu_mul_param #(.EXP_W(8), .MAN_W(23)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din1      (din1),
    .din2      (din2),
    .rm        (rm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  fpu_mul_param #(.EXP_W(5), .MAN_W(10)) u_half (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (h_in_valid),
    .in_ready  (h_in_ready),
    .din1      (h_din1),
    .din2      (h_din2),
    .rm        (h_rm),
    .out_valid (h_out_valid),
    .out_ready (h_out_ready),
    .result    (h_result),
    .flags     (h_flags)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One single-precision operation; latency counted in edges after accept.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] m, input logic [31:0] exp_r,
                        input logic [4:0] exp_f, input int exp_lat, input bit ack);
    int lat;
    @(negedge clk);
    chk({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    din1 = a; din2 = b; rm = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "/lat"},   32'(lat),   32'(exp_lat));
    chk({tag, "/res"},   result,     exp_r);
    chk({tag, "/flags"}, 32'(flags), 32'(exp_f));
    if (ack) begin
      @(posedge clk); #1;
      chk({tag, "/idle_ov"}, 32'(out_valid), 32'd0);
      chk({tag, "/idle_ir"}, 32'(in_ready),  32'd1);
    end
  endtask

  task automatic run_half(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] m, input logic [15:0] exp_r,
                          input logic [4:0] exp_f, input int exp_lat);
    int lat;
    @(negedge clk);
    h_din1 = a; h_din2 = b; h_rm = m; h_in_valid = 1'b1;
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    lat = 0;
    while (h_out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "/lat"},   32'(lat),     32'(exp_lat));
    chk({tag, "/res"},   32'(h_result), 32'(exp_r));
    chk({tag, "/flags"}, 32'(h_flags),  32'(exp_f));
    @(posedge clk); #1;
  endtask

  initial begin
    int seen;
    reset = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; din1 = '0; din2 = '0; rm = '0;
    h_in_valid = 1'b0; h_out_ready = 1'b1; h_din1 = '0; h_din2 = '0; h_rm = '0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst/in_ready",  32'(in_ready),  32'd1);
    chk("rst/out_valid", 32'(out_valid), 32'd0);
    chk("rst/result",    result,         32'd0);
    chk("rst/flags",     32'(flags),     32'd0);
    reset = 1'b1;

    // normal path
    run_op("mul3x2",   32'h40400000, 32'h40000000, 3'd0, 32'h40C00000, 5'h00, 6, 1'b1);
    run_op("negmul",   32'hC0400000, 32'h40000000, 3'd0, 32'hC0C00000, 5'h00, 6, 1'b1);
    // specials
    run_op("infx0",    32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 5'h10, 2, 1'b1);
    run_op("snan",     32'h7F800001, 32'h3F800000, 3'd0, 32'h7FC00000, 5'h10, 2, 1'b1);
    run_op("qnan",     32'h7FC00000, 32'h3F800000, 3'd0, 32'h7FC00000, 5'h00, 2, 1'b1);
    run_op("infxneg",  32'h7F800000, 32'hC0000000, 3'd0, 32'hFF800000, 5'h00, 2, 1'b1);
    run_op("negzero",  32'h80000000, 32'h40000000, 3'd0, 32'h80000000, 5'h00, 2, 1'b1);
    // overflow by rounding mode
    run_op("ovf_rne",  32'h7F7FFFFF, 32'h40000000, 3'd0, 32'h7F800000, 5'h05, 6, 1'b1);
    run_op("ovf_rtz",  32'h7F7FFFFF, 32'h40000000, 3'd1, 32'h7F7FFFFF, 5'h05, 6, 1'b1);
    run_op("ovf_rdn",  32'hFF7FFFFF, 32'h40000000, 3'd2, 32'hFF800000, 5'h05, 6, 1'b1);
    run_op("ovf_rdnp", 32'h7F7FFFFF, 32'h40000000, 3'd2, 32'h7F7FFFFF, 5'h05, 6, 1'b1);
    run_op("ovf_rupn", 32'hFF7FFFFF, 32'h40000000, 3'd3, 32'hFF7FFFFF, 5'h05, 6, 1'b1);
    // underflow: exact tie halfway between 0 and min subnormal
    run_op("uf_rne",   32'h00000001, 32'h3F000000, 3'd0, 32'h00000000, 5'h03, 6, 1'b1);
    run_op("uf_rup",   32'h00000001, 32'h3F000000, 3'd3, 32'h00000001, 5'h03, 6, 1'b1);
    run_op("uf_rmm",   32'h00000001, 32'h3F000000, 3'd4, 32'h00000001, 5'h03, 6, 1'b1);
    run_op("uf_rm7",   32'h00000001, 32'h3F000000, 3'd7, 32'h00000000, 5'h03, 6, 1'b1);
    // subnormal input, denormal rounding into min normal
    run_op("subin",    32'h00400000, 32'h40000000, 3'd0, 32'h00800000, 5'h00, 6, 1'b1);
    run_op("den2norm", 32'h007FFFFF, 32'h3F800001, 3'd0, 32'h00800000, 5'h03, 6, 1'b1);
    // sticky-only inexact
    run_op("stk_rne",  32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 5'h01, 6, 1'b1);
    run_op("stk_rup",  32'h3F800001, 32'h3F800001, 3'd3, 32'h3F800003, 5'h01, 6, 1'b1);
    run_op("stk_rdn",  32'hBF800001, 32'h3F800001, 3'd2, 32'hBF800003, 5'h01, 6, 1'b1);

    // back-pressure: outputs hold, new operands ignored
    @(negedge clk);
    out_ready = 1'b0;
    run_op("bp", 32'h40400000, 32'h40000000, 3'd0, 32'h40C00000, 5'h00, 6, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; din1 = 32'h3F800000; din2 = 32'h3F800000; rm = 3'd0;
      chk("bp/result",    result,         32'h40C00000);
      chk("bp/flags",     32'(flags),     32'h00);
      chk("bp/out_valid", 32'(out_valid), 32'd1);
      chk("bp/in_ready",  32'(in_ready),  32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp/rel_ov", 32'(out_valid), 32'd0);
    chk("bp/rel_ir", 32'(in_ready),  32'd1);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    chk("bp/no_ghost", 32'(seen), 32'd0);

    // reset while in MULT
    @(negedge clk);
    din1 = 32'h40400000; din2 = 32'h40000000; rm = 3'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("mrst/in_ready",  32'(in_ready),  32'd1);
    chk("mrst/out_valid", 32'(out_valid), 32'd0);
    chk("mrst/result",    result,         32'd0);
    chk("mrst/flags",     32'(flags),     32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    chk("mrst/no_stale", 32'(seen), 32'd0);
    run_op("post_rst", 32'h40400000, 32'h40000000, 3'd0, 32'h40C00000, 5'h00, 6, 1'b1);

    // half precision
    run_half("h3x2",   16'h4200, 16'h4000, 3'd0, 16'h4600, 5'h00, 6);
    run_half("h_ovf",  16'h7BFF, 16'h4000, 3'd0, 16'h7C00, 5'h05, 6);
    run_half("h_ovfz", 16'h7BFF, 16'h4000, 3'd1, 16'h7BFF, 5'h05, 6);
    run_half("h_ufne", 16'h0001, 16'h3800, 3'd0, 16'h0000, 5'h03, 6);
    run_half("h_ufup", 16'h0001, 16'h3800, 3'd3, 16'h0001, 5'h03, 6);
    run_half("h_infz", 16'h7C00, 16'h0000, 3'd0, 16'h7E00, 5'h10, 2);
    run_half("h_sub",  16'h0200, 16'h4000, 3'd0, 16'h0400, 5'h00, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
